// File: rtl/hough_pkg.sv
// Shared Hough constants and sweep state type, also used by the accumulator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hough_pkg;

    localparam int          ANGLE_W         = 8;
    localparam logic [7:0]  ANGLE_MIN       = 8'd1;
    localparam logic [7:0]  ANGLE_MAX       = 8'd180;
    localparam logic [7:0]  ANGLE_ZERO_IDX  = 8'd1;   // 0 degrees: cos is exactly 1.0
    localparam logic [7:0]  ANGLE_RIGHT_IDX = 8'd91;  // 90 degrees: sin is 1.0, cos is 0

    localparam int          Q_FRAC          = 16;
    localparam logic [16:0] Q_ONE           = 17'h10000;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/hough_rho_mac.sv
// Two-stage rho datapath: stage 1 multiplies |cos|,|sin| by x,y; stage 2 signs, sums, scales, saturates.
// Latency: 2 cycles from issue to registered vote.
// Backpressure: en_i low freezes both stages (valids and data) so the output vote holds stable.
// Build option HOUGH_RHO_ROUND_EN: round half up when dropping the Q0.16 fraction; otherwise floor.
module hough_rho_mac
    import hough_pkg::*;
#(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int RHO_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    issue_vld_i,
    input  logic [ANGLE_W-1:0]      angle_i,
    input  logic [X_W-1:0]          x_i,
    input  logic [Y_W-1:0]          y_i,
    input  logic [15:0]             cos_i,
    input  logic [15:0]             sin_i,
    output logic                    s1_vld_o,
    output logic                    vote_vld_o,
    output logic [ANGLE_W-1:0]      vote_angle_o,
    output logic [RHO_W-1:0]        vote_rho_o
);

    localparam int MW = (X_W > Y_W) ? X_W : Y_W;
    localparam int SW = MW + 19;

    localparam logic signed [SW-1:0] RHO_MAX = SW'((64'sd1 <<< (RHO_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] RHO_MIN = ~RHO_MAX;

    // Stage-1 operands: 17-bit magnitudes so that exact 1.0 can be represented
    logic [16:0]        cos_mag;
    logic [16:0]        sin_mag;
    logic [X_W+16:0]    px_d;
    logic [Y_W+16:0]    py_d;
    logic               neg_d;

    // Stage-1 registers
    logic               s1_vld_q;
    logic [X_W+16:0]    px_q;
    logic [Y_W+16:0]    py_q;
    logic               neg_q;
    logic [ANGLE_W-1:0] ang1_q;

    // Stage-2 signals
    logic signed [SW-1:0] px_ext;
    logic signed [SW-1:0] py_ext;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_adj;
    logic signed [SW-1:0] rho_full;
    logic [RHO_W-1:0]     rho_d;

    // Stage-2 registers
    logic                 vote_vld_q;
    logic [ANGLE_W-1:0]   vote_angle_q;
    logic [RHO_W-1:0]     vote_rho_q;

    // Unity substitution at 0/90 degrees, forced zero cos at 90, then unsigned products
    always_comb begin
        cos_mag = {1'b0, cos_i};
        sin_mag = {1'b0, sin_i};
        if (angle_i == ANGLE_ZERO_IDX) begin
            cos_mag = Q_ONE;
        end
        if (angle_i == ANGLE_RIGHT_IDX) begin
            cos_mag = '0;
            sin_mag = Q_ONE;
        end
        px_d  = {17'd0, x_i} * {{X_W{1'b0}}, cos_mag};
        py_d  = {17'd0, y_i} * {{Y_W{1'b0}}, sin_mag};
        neg_d = (angle_i > ANGLE_RIGHT_IDX);
    end

    // Stage-1 register: products, cos sign and angle tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            neg_q    <= 1'b0;
            ang1_q   <= '0;
        end else if (en_i) begin
            s1_vld_q <= issue_vld_i;
            if (issue_vld_i) begin
                px_q   <= px_d;
                py_q   <= py_d;
                neg_q  <= neg_d;
                ang1_q <= angle_i;
            end
        end
    end

    // Signed sum, drop the Q0.16 fraction, clamp to the output width
    always_comb begin
        px_ext = $signed({{(SW - X_W - 17){1'b0}}, px_q});
        py_ext = $signed({{(SW - Y_W - 17){1'b0}}, py_q});
        sum    = neg_q ? (py_ext - px_ext) : (py_ext + px_ext);
`ifdef HOUGH_RHO_ROUND_EN
        sum_adj = sum + (SW'(1) <<< (Q_FRAC - 1));
`else
        sum_adj = sum;
`endif
        rho_full = sum_adj >>> Q_FRAC;
        if (rho_full > RHO_MAX) begin
            rho_d = RHO_MAX[RHO_W-1:0];
        end else if (rho_full < RHO_MIN) begin
            rho_d = RHO_MIN[RHO_W-1:0];
        end else begin
            rho_d = rho_full[RHO_W-1:0];
        end
    end

    // Stage-2 register: the vote presented downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_vld_q   <= 1'b0;
            vote_angle_q <= '0;
            vote_rho_q   <= '0;
        end else if (en_i) begin
            vote_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                vote_angle_q <= ang1_q;
                vote_rho_q   <= rho_d;
            end
        end
    end

    assign s1_vld_o     = s1_vld_q;
    assign vote_vld_o   = vote_vld_q;
    assign vote_angle_o = vote_angle_q;
    assign vote_rho_o   = vote_rho_q;

endmodule

// File: rtl/hough_rho_sweep.sv
// Per-pixel angle sweeper: walks angle 1..180, drives cos/sin LUTs, emits one (angle, rho) vote per cycle.
// Latency: 2 cycles from pixel accept to first vote; 180 votes per pixel, back-to-back pixels without bubble.
// Backpressure: vote_valid && !vote_ready freezes angle, latched pixel and both pipeline stages.
// Build option HOUGH_RHO_ROUND_EN selects round-half-up rho (default floor).
module hough_rho_sweep
    import hough_pkg::*;
#(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int RHO_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [X_W-1:0]      pix_x,
    input  logic [Y_W-1:0]      pix_y,
    output logic [7:0]          angle_value,
    input  logic [15:0]         cos_value,
    input  logic [15:0]         sin_value,
    output logic                vote_valid,
    input  logic                vote_ready,
    output logic [7:0]          vote_angle,
    output logic [RHO_W-1:0]    vote_rho,
    output logic                busy
);

    sweep_state_t       state_q, state_d;
    logic [7:0]         angle_q, angle_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;

    logic               stall;
    logic               issue;
    logic               s1_vld;

    assign stall = vote_valid && !vote_ready;

    // Sweep control: accept pixels, step the angle, chain pixels at angle 180
    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_ready = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    x_d     = pix_x;
                    y_d     = pix_y;
                    angle_d = ANGLE_MIN;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (angle_q == ANGLE_MAX) begin
                        pix_ready = 1'b1;
                        angle_d   = ANGLE_MIN;
                        if (pix_valid) begin
                            x_d = pix_x;
                            y_d = pix_y;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        angle_d = angle_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                angle_d = ANGLE_MIN;
            end
        endcase
    end

    // Sweep state, angle and latched pixel registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            angle_q <= ANGLE_MIN;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    hough_rho_mac #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .RHO_W (RHO_W)
    ) u_mac (
        .clk          (clk),
        .rst          (rst),
        .en_i         (!stall),
        .issue_vld_i  (issue),
        .angle_i      (angle_q),
        .x_i          (x_q),
        .y_i          (y_q),
        .cos_i        (cos_value),
        .sin_i        (sin_value),
        .s1_vld_o     (s1_vld),
        .vote_vld_o   (vote_valid),
        .vote_angle_o (vote_angle),
        .vote_rho_o   (vote_rho)
    );

    assign angle_value = angle_q;
    assign busy        = (state_q == SWEEP) || s1_vld || vote_valid;

endmodule

// File: tb/tb_hough_rho_sweep.sv
// Directed bench for hough_rho_sweep: table of per-angle rho vectors plus hand-written corner sequences.
// A second instance with RHO_W=11 shares the stimulus to exercise output saturation.
module tb_hough_rho_sweep;

    localparam int X_W = 10;
    localparam int Y_W = 10;
`ifdef HOUGH_RHO_ROUND_EN
    localparam int PEAK_RHO  = 1447;
    localparam int STALL_RHO = 78;
`else
    localparam int PEAK_RHO  = 1446;
    localparam int STALL_RHO = 77;
`endif
    localparam real PI = 3.14159265358979;

    logic           clk = 1'b0;
    logic           rst;
    logic           pix_valid;
    logic           pix_ready;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [7:0]     angle_value;
    logic [15:0]    cos_value, sin_value;
    logic           vote_valid;
    logic           vote_ready;
    logic [7:0]     vote_angle;
    logic [11:0]    vote_rho;
    logic           busy;

    logic           pix_ready_s;
    logic [7:0]     angle_value_s;
    logic [15:0]    cos_value_s, sin_value_s;
    logic           vote_valid_s;
    logic [7:0]     vote_angle_s;
    logic [10:0]    vote_rho_s;
    logic           busy_s;

    always #5 clk = ~clk;

    function automatic logic [15:0] lut(input logic [7:0] a, input bit is_cos);
        real deg, r;
        int  v;
        deg = real'(int'(a) - 1);
        r   = is_cos ? $cos(deg * PI / 180.0) : $sin(deg * PI / 180.0);
        if (r < 0.0) r = -r;
        v = $rtoi(r * 65536.0 + 0.5);
        if (v > 65535) v = 65535;
        return 16'(v);
    endfunction

    assign cos_value   = lut(angle_value, 1'b1);
    assign sin_value   = lut(angle_value, 1'b0);
    assign cos_value_s = lut(angle_value_s, 1'b1);
    assign sin_value_s = lut(angle_value_s, 1'b0);

    hough_rho_sweep #(.X_W(X_W), .Y_W(Y_W), .RHO_W(12)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .angle_value(angle_value),
        .cos_value(cos_value), .sin_value(sin_value),
        .vote_valid(vote_valid), .vote_ready(vote_ready),
        .vote_angle(vote_angle), .vote_rho(vote_rho), .busy(busy)
    );

    hough_rho_sweep #(.X_W(X_W), .Y_W(Y_W), .RHO_W(11)) u_sat (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready_s),
        .pix_x(pix_x), .pix_y(pix_y), .angle_value(angle_value_s),
        .cos_value(cos_value_s), .sin_value(sin_value_s),
        .vote_valid(vote_valid_s), .vote_ready(vote_ready),
        .vote_angle(vote_angle_s), .vote_rho(vote_rho_s), .busy(busy_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Vote monitor: order check and per-angle rho log for the most recent pixel
    int exp_next = 1;
    int vote_cnt = 0;
    int rho_log[1:180];
    int sat_log[1:180];

    always @(negedge clk) begin
        if (rst) begin
            exp_next = 1;
        end else begin
            if (vote_valid && vote_ready) begin
                chk("vote_order", int'(vote_angle), exp_next);
                if (vote_angle >= 8'd1 && vote_angle <= 8'd180)
                    rho_log[vote_angle] = $signed(vote_rho);
                exp_next = (exp_next == 180) ? 1 : exp_next + 1;
                vote_cnt++;
            end
            if (vote_valid_s && vote_ready && vote_angle_s >= 8'd1 && vote_angle_s <= 8'd180)
                sat_log[vote_angle_s] = $signed(vote_rho_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y);
        int n;
        pix_x     = X_W'(x);
        pix_y     = Y_W'(y);
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("accept_timeout", 0, 1);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    typedef struct {
        int x;
        int y;
        int angle;
        int rho;
        int rho_sat;
    } vec_t;

    vec_t vt[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;

        vt[0]  = '{100, 0, 1, 100, 100};
        vt[1]  = '{100, 0, 61, 50, 50};
        vt[2]  = '{100, 0, 91, 0, 0};
        vt[3]  = '{100, 0, 121, -50, -50};
        vt[4]  = '{100, 0, 180, -100, -100};
        vt[5]  = '{0, 200, 91, 200, 200};
        vt[6]  = '{0, 200, 1, 0, 0};
        vt[7]  = '{0, 200, 31, 100, 100};
        vt[8]  = '{1023, 1023, 1, 1023, 1023};
        vt[9]  = '{1023, 1023, 91, 1023, 1023};
        vt[10] = '{1023, 1023, 46, PEAK_RHO, 1023};

        rst        = 1'b1;
        pix_valid  = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        vote_ready = 1'b1;
        tick();
        tick();
        chk("rst_pix_ready",   int'(pix_ready), 1);
        chk("rst_angle_value", int'(angle_value), 1);
        chk("rst_vote_valid",  int'(vote_valid), 0);
        chk("rst_vote_angle",  int'(vote_angle), 0);
        chk("rst_vote_rho",    int'(vote_rho), 0);
        chk("rst_busy",        int'(busy), 0);
        rst = 1'b0;
        tick();

        // First-vote latency
        send(100, 0);
        chk("lat_n_angle",  int'(angle_value), 1);
        chk("lat_n_valid",  int'(vote_valid), 0);
        chk("lat_n_busy",   int'(busy), 1);
        chk("lat_n_ready",  int'(pix_ready), 0);
        tick();
        chk("lat_n1_valid", int'(vote_valid), 0);
        chk("lat_n1_angle", int'(angle_value), 2);
        tick();
        chk("lat_n2_valid", int'(vote_valid), 1);
        chk("lat_n2_vangle", int'(vote_angle), 1);
        chk("lat_n2_rho",   int'($signed(vote_rho)), 100);
        wait_idle();

        // Table of per-angle rho values
        for (int i = 0; i < 11; i++) begin
            if (i == 0 || vt[i].x != vt[i-1].x || vt[i].y != vt[i-1].y) begin
                c0 = vote_cnt;
                send(vt[i].x, vt[i].y);
                wait_idle();
                chk($sformatf("vote_count x%0d y%0d", vt[i].x, vt[i].y), vote_cnt - c0, 180);
            end
            chk($sformatf("rho x%0d y%0d a%0d", vt[i].x, vt[i].y, vt[i].angle),
                rho_log[vt[i].angle], vt[i].rho);
            chk($sformatf("rho11 x%0d y%0d a%0d", vt[i].x, vt[i].y, vt[i].angle),
                sat_log[vt[i].angle], vt[i].rho_sat);
        end

        // Back-to-back pixels: A=(100,0) then B=(0,200)
        pix_x     = 10'd100;
        pix_y     = 10'd0;
        pix_valid = 1'b1;
        chk("b2b_ready_idle", int'(pix_ready), 1);
        tick();
        pix_x = 10'd0;
        pix_y = 10'd200;
        n = 0;
        while (!pix_ready && n < 400) begin
            tick();
            n++;
        end
        chk("b2b_ready_wait", n, 179);
        chk("b2b_issue_angle", int'(angle_value), 180);
        tick();
        pix_valid = 1'b0;
        chk("b2b_ready_after", int'(pix_ready), 0);
        chk("b2b_angle_wrap",  int'(angle_value), 1);
        chk("b2b_vote179",     int'(vote_angle), 179);
        tick();
        chk("b2b_vote180_vld", int'(vote_valid), 1);
        chk("b2b_vote180",     int'(vote_angle), 180);
        tick();
        chk("b2b_voteB1_vld",  int'(vote_valid), 1);
        chk("b2b_voteB1",      int'(vote_angle), 1);
        chk("b2b_voteB1_rho",  int'($signed(vote_rho)), 0);
        wait_idle();
        chk("b2b_B_rho91", rho_log[91], 200);

        // Stall at vote angle 40 for 5 cycles
        c0 = vote_cnt;
        send(100, 0);
        n = 0;
        while (!(vote_valid && vote_angle == 8'd40) && n < 400) begin
            tick();
            n++;
        end
        chk("stall_reach40", int'(vote_angle), 40);
        vote_ready = 1'b0;
        chk("stall_angle_value", int'(angle_value), 42);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid", int'(vote_valid), 1);
            chk("stall_vangle", int'(vote_angle), 40);
            chk("stall_rho", int'($signed(vote_rho)), STALL_RHO);
            chk("stall_angle_frozen", int'(angle_value), 42);
        end
        vote_ready = 1'b1;
        tick();
        chk("stall_resume", int'(vote_angle), 41);
        wait_idle();
        chk("stall_vote_count", vote_cnt - c0, 180);
        chk("stall_rho40_log", rho_log[40], STALL_RHO);

        // Reset at angle 90 mid-sweep
        send(100, 0);
        n = 0;
        while (angle_value != 8'd90 && n < 400) begin
            tick();
            n++;
        end
        chk("rst_reach90", int'(angle_value), 90);
        rst = 1'b1;
        tick();
        chk("midrst_vote_valid", int'(vote_valid), 0);
        chk("midrst_busy",       int'(busy), 0);
        chk("midrst_pix_ready",  int'(pix_ready), 1);
        chk("midrst_angle",      int'(angle_value), 1);
        rst = 1'b0;
        c0 = vote_cnt;
        tick();
        tick();
        tick();
        chk("postrst_no_votes", vote_cnt - c0, 0);
        chk("postrst_busy",     int'(busy), 0);
        send(0, 200);
        tick();
        tick();
        chk("postrst_first_vote", int'(vote_angle), 1);
        wait_idle();
        chk("postrst_vote_count", vote_cnt - c0, 180);
        chk("postrst_rho31", rho_log[31], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
